// File: rtl/input_port_ctrl_if.sv
// Handshake bundle between an input port front end and its surroundings
// (link, routing lookup, switch allocator, crossbar).
interface input_port_ctrl_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 4
);
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_SIZE-1:0] dest_sw;
    logic [3:0]           port_num;
    logic                 req;
    logic [3:0]           req_port;
    logic                 grant;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err;

    // Environment side: link source, routing table, allocator, crossbar sink.
    modport master (
        output in_data, in_valid, port_num, grant, out_ready,
        input  in_ready, dest_sw, req, req_port, out_data, out_valid, err
    );

    // Input port controller side.
    modport slave (
        input  in_data, in_valid, port_num, grant, out_ready,
        output in_ready, dest_sw, req, req_port, out_data, out_valid, err
    );
endinterface

// File: rtl/input_port_ctrl.sv
// Input port front end: flit FIFO, head-flit route lookup, allocator request, packet streaming.
// Optional macro ROUTE_CHECK_EN: drop packets whose looked-up port is >= PORTS_NUM.
module input_port_ctrl #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned PORTS_NUM = 5,
    parameter int unsigned BUF_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    input_port_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);

    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 ||
        PORTS_NUM < 1 || PORTS_NUM > 16 || ADDR_SIZE > DATA_SIZE - 2) begin : g_bad_cfg
        $error("input_port_ctrl: unsupported BUF_DEPTH, PORTS_NUM or ADDR_SIZE");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_REQ,
        ST_ACTIVE
`ifdef ROUTE_CHECK_EN
        , ST_DROP
`endif
    } state_t;

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_mem [BUF_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic                 r_req;
    logic [3:0]           r_req_port;
    logic                 r_err;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_start;
    logic                 w_end;
    logic [DATA_SIZE-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = bus.in_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    // Type bit 0 marks HEAD/SINGLE (packet start), bit 1 marks TAIL/SINGLE (packet end).
    assign w_start = w_head[DATA_SIZE-2];
    assign w_end   = w_head[DATA_SIZE-1];

    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            case (r_state)
                ST_IDLE:   w_pop = !w_start;
                ST_ACTIVE: w_pop = bus.out_ready;
`ifdef ROUTE_CHECK_EN
                ST_DROP:   w_pop = 1'b1;
`endif
                default:   w_pop = 1'b0;
            endcase
        end
    end

    // Storage is cleared on reset so dest_sw/out_data are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_req_port <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_start) begin
                            r_state <= ST_ROUTE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ROUTE: begin
`ifdef ROUTE_CHECK_EN
                    if (32'(bus.port_num) >= PORTS_NUM) begin
                        r_state <= ST_DROP;
                        r_err   <= 1'b1;
                    end else
`endif
                    begin
                        r_req_port <= bus.port_num;
                        r_req      <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.grant) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_pop && w_end) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
`ifdef ROUTE_CHECK_EN
                ST_DROP: begin
                    if (w_pop && w_end) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.dest_sw   = w_head[ADDR_SIZE-1:0];
    assign bus.req       = r_req;
    assign bus.req_port  = r_req_port;
    assign bus.out_data  = w_head;
    assign bus.out_valid = (r_state == ST_ACTIVE) && !w_empty;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl: routing, allocator wait, backpressure, stray flits,
// optional bad-route drop (ROUTE_CHECK_EN) and asynchronous reset mid-packet.
module tb_input_port_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic clk;
    logic rst_n;
    int unsigned n_cmp;
    int unsigned n_mis;
    logic [3:0] route_tbl [16];

    input_port_ctrl_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    input_port_ctrl #(
        .DATA_SIZE(DW),
        .ADDR_SIZE(AW),
        .PORTS_NUM(5),
        .BUF_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Combinational routing table: dest -> output port.
    assign bus.port_num = route_tbl[bus.dest_sw];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] f);
        bus.in_valid = 1'b1;
        bus.in_data  = f;
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [25:0] pl, input logic [3:0] d);
        return {t, pl, d};
    endfunction

    localparam logic [1:0] T_HEAD = 2'b01, T_BODY = 2'b00, T_TAIL = 2'b10, T_SINGLE = 2'b11;

    logic [DW-1:0] pkt [6];
    logic [DW-1:0] sflit;
    int unsigned   sent, got, n_req, n_ov, n_errp;
    logic          acc, popd;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        for (int i = 0; i < 16; i++) route_tbl[i] = 4'd0;
        route_tbl[3]  = 4'd2;
        route_tbl[5]  = 4'd1;
        route_tbl[7]  = 4'd3;
        route_tbl[15] = 4'hF;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.grant     = 1'b0;
        bus.out_ready = 1'b1;
        #22;
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_req", bus.req, 1'b0);
        check_eq("rst_req_port", bus.req_port, 4'd0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        check_eq("rst_dest_sw", bus.dest_sw, 4'd0);
        tick();

        // SINGLE dest=3 -> port 2, grant in the same cycle as req
        sflit = mk(T_SINGLE, 26'h0ABCDE, 4'd3);
        push(sflit);
        check_eq("t1_dest_sw", bus.dest_sw, 4'd3);
        check_eq("t1_c0_req", bus.req, 1'b0);
        tick();
        check_eq("t1_c1_req", bus.req, 1'b0);
        check_eq("t1_c1_out_valid", bus.out_valid, 1'b0);
        tick();
        check_eq("t1_c2_req", bus.req, 1'b1);
        check_eq("t1_c2_req_port", bus.req_port, 4'd2);
        check_eq("t1_c2_out_valid", bus.out_valid, 1'b0);
        bus.grant = 1'b1;
        tick();
        bus.grant = 1'b0;
        check_eq("t1_c3_out_valid", bus.out_valid, 1'b1);
        check_eq("t1_c3_out_data", bus.out_data, sflit);
        tick();
        check_eq("t1_c4_out_valid", bus.out_valid, 1'b0);
        check_eq("t1_c4_req", bus.req, 1'b0);

        // HEAD/BODY/BODY/TAIL dest=5 -> port 1, grant five cycles after req rises
        pkt[0] = mk(T_HEAD, 26'h0000011, 4'd5);
        pkt[1] = mk(T_BODY, 26'h0000022, 4'd0);
        pkt[2] = mk(T_BODY, 26'h0000033, 4'd1);
        pkt[3] = mk(T_TAIL, 26'h0000044, 4'd2);
        for (int k = 0; k < 4; k++) push(pkt[k]);
        check_eq("t2_req_c2", bus.req, 1'b1);
        check_eq("t2_req_port", bus.req_port, 4'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t2_req_hold", bus.req, 1'b1);
            check_eq("t2_no_out", bus.out_valid, 1'b0);
        end
        bus.grant = 1'b1;
        tick();
        bus.grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("t2_out_valid", bus.out_valid, 1'b1);
            check_eq("t2_out_data", bus.out_data, pkt[k]);
            tick();
        end
        check_eq("t2_end_req", bus.req, 1'b0);
        check_eq("t2_end_out_valid", bus.out_valid, 1'b0);

        // Backpressure: 6-flit packet, out_ready low until the FIFO fills
        pkt[0] = mk(T_HEAD, 26'h1000001, 4'd7);
        for (int k = 1; k < 5; k++) pkt[k] = mk(T_BODY, 26'h2000000 + 26'(k), 4'(k));
        pkt[5] = mk(T_TAIL, 26'h3FFFFFF, 4'hA);
        bus.out_ready = 1'b0;
        bus.grant     = 1'b1;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = (sent < 6);
            bus.in_data  = pkt[sent < 6 ? sent : 0];
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) sent++;
        end
        check_eq("t3_accepts", sent, 32'd4);
        check_eq("t3_in_ready_full", bus.in_ready, 1'b0);
        check_eq("t3_req_port", bus.req_port, 4'd3);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            bus.in_valid = (sent < 6);
            bus.in_data  = pkt[sent < 6 ? sent : 0];
            acc  = bus.in_valid && bus.in_ready;
            popd = bus.out_valid && bus.out_ready;
            if (popd) check_eq("t3_out_data", bus.out_data, pkt[got]);
            tick();
            if (acc) sent++;
            if (popd) got++;
        end
        bus.in_valid = 1'b0;
        bus.grant    = 1'b0;
        check_eq("t3_all_sent", sent, 32'd6);
        check_eq("t3_all_recv", got, 32'd6);
        check_eq("t3_end_req", bus.req, 1'b0);

        // Stray BODY while IDLE: dropped with a one-cycle err pulse
        push(mk(T_BODY, 26'h0BAD000, 4'd3));
        check_eq("t4_err_early", bus.err, 1'b0);
        tick();
        check_eq("t4_err_pulse", bus.err, 1'b1);
        check_eq("t4_req", bus.req, 1'b0);
        tick();
        check_eq("t4_err_clear", bus.err, 1'b0);
        check_eq("t4_req_after", bus.req, 1'b0);
        check_eq("t4_out_valid", bus.out_valid, 1'b0);

`ifdef ROUTE_CHECK_EN
        // Unroutable destination: whole packet popped, single err, no req
        pkt[0] = mk(T_HEAD, 26'h0D00001, 4'd15);
        pkt[1] = mk(T_BODY, 26'h0D00002, 4'd0);
        pkt[2] = mk(T_TAIL, 26'h0D00003, 4'd0);
        n_req = 0; n_ov = 0; n_errp = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c < 3);
            bus.in_data  = pkt[c < 3 ? c : 0];
            tick();
            if (bus.req) n_req++;
            if (bus.out_valid) n_ov++;
            if (bus.err) n_errp++;
        end
        bus.in_valid = 1'b0;
        check_eq("t5_err_count", n_errp, 32'd1);
        check_eq("t5_req_count", n_req, 32'd0);
        check_eq("t5_out_valid_count", n_ov, 32'd0);
`endif

        // Reset mid-packet after two of four flits have left
        pkt[0] = mk(T_HEAD, 26'h0E00001, 4'd3);
        pkt[1] = mk(T_BODY, 26'h0E00002, 4'd0);
        pkt[2] = mk(T_BODY, 26'h0E00003, 4'd0);
        pkt[3] = mk(T_TAIL, 26'h0E00004, 4'd0);
        bus.out_ready = 1'b0;
        bus.grant     = 1'b1;
        for (int k = 0; k < 4; k++) push(pkt[k]);
        bus.grant     = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check_eq("t6_out_data", bus.out_data, pkt[k]);
            tick();
        end
        check_eq("t6_pre_rst_valid", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req", bus.req, 1'b0);
        check_eq("t6_rst_out_valid", bus.out_valid, 1'b0);
        check_eq("t6_rst_in_ready", bus.in_ready, 1'b1);
        #1 rst_n = 1'b1;
        tick();
        sflit = mk(T_SINGLE, 26'h0F00F00, 4'd5);
        push(sflit);
        tick();
        tick();
        check_eq("t6_new_req", bus.req, 1'b1);
        check_eq("t6_new_req_port", bus.req_port, 4'd1);
        bus.grant = 1'b1;
        tick();
        bus.grant = 1'b0;
        check_eq("t6_new_out_valid", bus.out_valid, 1'b1);
        check_eq("t6_new_out_data", bus.out_data, sflit);
        tick();
        check_eq("t6_new_done_req", bus.req, 1'b0);
        check_eq("t6_new_done_valid", bus.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
